// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// framing constants and the memory depth helper.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_HEADER = 3'd1;
  localparam state_t S_DATA   = 3'd2;
  localparam state_t S_WRITE  = 3'd3;
  localparam state_t S_CHECK  = 3'd4;
  localparam state_t S_DONE   = 3'd5;
  localparam state_t S_ERROR  = 3'd6;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/imem_loader_asm.sv
// Byte-to-word assembler: little-endian byte insertion, running XOR checksum.
// A completed word is latched into word on the 4th byte and held until the next one.
module imem_loader_asm
  import imem_loader_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [7:0]   data,
  output logic         last,
  output logic [N-1:0] word,
  output logic [7:0]   csum
);

  logic [1:0]   idx;
  logic [N-1:0] wbuf;
  logic [N-1:0] next_word;

  assign last = (idx == 2'(BYTES_PER_WORD - 1));

  always_comb begin
    next_word = wbuf;
    next_word[8*idx +: 8] = data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx  <= 2'd0;
      wbuf <= '0;
      word <= '0;
      csum <= 8'd0;
    end else if (clear) begin
      idx  <= 2'd0;
      wbuf <= '0;
      csum <= 8'd0;
    end else if (load) begin
      wbuf <= next_word;
      csum <= csum ^ data;
      idx  <= idx + 2'd1;
      // Only publish complete words so wr_data stays stable between writes.
      if (last)
        word <= next_word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a framed program (count, LE words, XOR checksum) into imem at 0,1,2,...
// One write per 4 bytes; byte_ready drops for the write cycle; cpu_reset released only after a good checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int N      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [N-1:0]      wr_data,
  output logic [ADDR_W:0]   word_count,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int DEPTH = depth_of(ADDR_W);

  state_t          state;
  logic [ADDR_W:0] target;
  logic [ADDR_W:0] count_next;
  logic            fire;
  logic            hdr_ok;
  logic            asm_clear;
  logic            asm_load;
  logic            asm_last;
  logic [7:0]      csum;

  assign byte_ready = (state == S_HEADER) || (state == S_DATA) || (state == S_CHECK);
  assign busy       = byte_ready || (state == S_WRITE);
  assign wr_en      = (state == S_WRITE);
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERROR);
  assign cpu_reset  = (state != S_DONE);

  assign fire       = byte_valid && byte_ready;
  assign hdr_ok     = (byte_data != 8'd0) && (int'(byte_data) <= DEPTH);
  assign asm_clear  = (state == S_HEADER) && fire && hdr_ok;
  assign asm_load   = (state == S_DATA) && fire;
  assign count_next = word_count + 1'b1;

  imem_loader_asm #(.N(N)) u_asm (
    .clk   (clk),
    .reset (reset),
    .clear (asm_clear),
    .load  (asm_load),
    .data  (byte_data),
    .last  (asm_last),
    .word  (wr_data),
    .csum  (csum)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      target     <= '0;
      word_count <= '0;
      wr_addr    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start)
            state <= S_HEADER;
        end
        S_HEADER: begin
          if (fire) begin
            if (hdr_ok) begin
              target     <= (ADDR_W+1)'(byte_data);
              word_count <= '0;
              wr_addr    <= '0;
              state      <= S_DATA;
            end else begin
              state <= S_ERROR;
            end
          end
        end
        S_DATA: begin
          if (fire && asm_last)
            state <= S_WRITE;
        end
        S_WRITE: begin
          word_count <= count_next;
          // Saturate rather than wrap when the program fills the whole memory.
          if (wr_addr != {ADDR_W{1'b1}})
            wr_addr <= wr_addr + 1'b1;
          state <= (count_next == target) ? S_CHECK : S_DATA;
        end
        S_CHECK: begin
          if (fire)
            state <= (byte_data == csum) ? S_DONE : S_ERROR;
        end
        S_DONE, S_ERROR: begin
          if (start)
            state <= S_HEADER;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, bad header/checksum, full memory, backpressure, reset abort.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic [6:0]  word_count;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(6), .N(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .word_count (word_count),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  int          tests = 0;
  int          fails = 0;
  int          bp_viol = 0;
  logic [7:0]  stream[$];
  logic [5:0]  wa[$];
  logic [31:0] wd[$];

  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
      if (byte_ready)
        bp_viol++;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Holds byte_valid high, advancing only on cycles where byte_ready was seen.
  task automatic run_stream(input int start_at, output int cyc);
    int   i;
    logic acc;
    i   = 0;
    cyc = 0;
    while (i < stream.size() && cyc < 4 * stream.size() + 20) begin
      byte_valid = 1'b1;
      byte_data  = stream[i];
      start      = (cyc == start_at);
      acc        = byte_ready;
      @(negedge clk);
      cyc++;
      if (acc)
        i++;
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    check("stream_consumed", i, stream.size());
    #1;
  endtask

  task automatic load_two_words(input logic [7:0] last_byte);
    stream = '{8'h02, 8'h01, 8'h00, 8'h00, 8'hf8, 8'h02, 8'h80, 8'h00, 8'hf8, last_byte};
  endtask

  initial begin
    int cyc;
    int bad;
    int zero_writes;

    reset      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_flags", {byte_ready, wr_en, busy, done, error}, 5'b0);
    check("rst_regs", {wr_addr, wr_data, word_count}, 45'd0);
    reset = 1'b1;

    // 2-word load with good checksum
    clear_log();
    pulse_start();
    check("hdr_busy_ready", {busy, byte_ready}, 2'b11);
    load_two_words(8'h83);
    run_stream(-1, cyc);
    check("ok_latency", cyc, 12);
    check("ok_flags", {done, error, cpu_reset, busy}, 4'b1000);
    check("ok_count", word_count, 2);
    check("ok_nwrites", wa.size(), 2);
    if (wa.size() == 2) begin
      check("ok_w0", {wa[0], wd[0]}, {6'd0, 32'hf8000001});
      check("ok_w1", {wa[1], wd[1]}, {6'd1, 32'hf8008002});
    end
    check("wr_data_hold", wr_data, 32'hf8008002);

    // Bad checksum: writes still land, then error
    clear_log();
    pulse_start();
    check("restart_cpu_reset", cpu_reset, 1);
    load_two_words(8'h84);
    run_stream(-1, cyc);
    check("bad_flags", {done, error, cpu_reset}, 3'b011);
    check("bad_nwrites", wa.size(), 2);

    // Header 0 and header 65 both rejected without writes
    clear_log();
    pulse_start();
    stream = '{8'h00};
    run_stream(-1, cyc);
    check("hdr0_error", {error, done, busy}, 3'b100);
    check("hdr0_nowrite", wa.size(), 0);
    clear_log();
    pulse_start();
    stream = '{8'h41};
    run_stream(-1, cyc);
    check("hdr65_error", {error, done, busy}, 3'b100);
    check("hdr65_nowrite", wa.size(), 0);

    // Full memory: word i = i; checksum of 0..63 is 0
    clear_log();
    pulse_start();
    stream = '{8'h40};
    for (int i = 0; i < 64; i++) begin
      stream.push_back(8'(i));
      stream.push_back(8'h00);
      stream.push_back(8'h00);
      stream.push_back(8'h00);
    end
    stream.push_back(8'h00);
    run_stream(-1, cyc);
    check("full_latency", cyc, 322);
    check("full_done", {done, error, cpu_reset}, 3'b100);
    check("full_count", word_count, 64);
    check("full_nwrites", wa.size(), 64);
    bad = 0;
    zero_writes = 0;
    foreach (wa[k]) begin
      if (wa[k] != 6'(k) || wd[k] != 32'(k))
        bad++;
      if (wa[k] == 6'd0)
        zero_writes++;
    end
    check("full_words_bad", bad, 0);
    check("full_addr0_writes", zero_writes, 1);
    if (wa.size() == 64)
      check("full_last", {wa[63], wd[63]}, {6'd63, 32'h0000003f});
    check("full_addr_sat", wr_addr, 6'd63);

    // start pulsed mid-DATA is ignored
    clear_log();
    pulse_start();
    load_two_words(8'h83);
    run_stream(3, cyc);
    check("midstart_done", {done, error}, 2'b10);
    check("midstart_nwrites", wa.size(), 2);
    if (wa.size() == 2)
      check("midstart_words", {wd[0], wd[1]}, {32'hf8000001, 32'hf8008002});
    check("bp_violations", bp_viol, 0);

    // Reset after 6 bytes aborts the load
    clear_log();
    pulse_start();
    stream = '{8'h02, 8'h01, 8'h00, 8'h00, 8'hf8, 8'h02};
    run_stream(-1, cyc);
    reset      = 1'b0;
    byte_valid = 1'b1;
    byte_data  = 8'h80;
    @(negedge clk);
    #1;
    check("abort_flags", {byte_ready, wr_en, busy, done, error, cpu_reset}, 6'b000001);
    check("abort_regs", {wr_addr, wr_data, word_count}, 45'd0);
    reset = 1'b1;
    clear_log();
    repeat (6) @(negedge clk);
    #1;
    check("abort_nowrite", wa.size(), 0);
    check("abort_idle", {busy, byte_ready}, 2'b00);
    byte_valid = 1'b0;

    // Recovery: 1-word load, checksum 12^34^56^78 = 08
    clear_log();
    pulse_start();
    stream = '{8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    run_stream(-1, cyc);
    check("recover_done", {done, error, cpu_reset}, 3'b100);
    check("recover_count", word_count, 1);
    check("recover_nwrites", wa.size(), 1);
    if (wa.size() == 1)
      check("recover_word", {wa[0], wd[0]}, {6'd0, 32'h12345678});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Sequential writer for the processor's instruction memory.
- Accepts a byte stream on a valid/ready interface and frames it as: header, little-endian 32-bit words, checksum.
- Issues one write per assembled word to a writable imem port at addresses 0, 1, 2, ...
- Holds the single-cycle processor in reset until a complete, checksum-verified program is loaded.

Parameters:
- ADDR_W, 6, word-address width of instruction memory; DEPTH = 2**ADDR_W words.
- N, 32, instruction word width; must be 32 (4 bytes per word).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse: begin (re)load
- byte_valid  in  1  host byte available
- byte_data  in  8  host byte
- byte_ready  out  1  loader can accept a byte this cycle
- wr_en  out  1  imem write strobe, one cycle per word
- wr_addr  out  ADDR_W  imem word address
- wr_data  out  N  assembled instruction word
- word_count  out  ADDR_W+1  words written in the current load
- cpu_reset  out  1  active-high reset to the processor
- busy  out  1  load in progress
- done  out  1  load finished, checksum good
- error  out  1  load aborted (bad header or checksum)

Behaviour:
- Byte transfer occurs on a posedge where byte_valid && byte_ready. The host must hold byte_data stable while valid and not yet accepted.
- Reset (reset==0 at posedge) puts the block in IDLE:
  - cpu_reset=1.
  - byte_ready, wr_en, busy, done, error = 0.
  - wr_addr, wr_data, word_count = 0.
  - Internal byte index, checksum and target count are cleared.
  - Reset mid-load aborts immediately; no further writes occur.
- States: IDLE, HEADER, DATA, WRITE, CHECK, DONE, ERROR.
- IDLE: start -> HEADER. byte_ready=0.
- HEADER: byte_ready=1; busy=1.
  - Accepted byte h is the word count.
  - h==0 or h>DEPTH -> ERROR.
  - Otherwise latch target=h, clear checksum, byte index, word_count and wr_addr, then go to DATA.
- DATA: byte_ready=1.
  - Each accepted byte is XORed into the checksum and placed into the word buffer at [8*idx+7:8*idx]; byte 0 is the LSB.
  - On the 4th byte (idx==3) go to WRITE.
- WRITE: exactly one cycle; byte_ready=0 (backpressure).
  - wr_en=1 with wr_addr = current address and wr_data = assembled word.
  - Next cycle: wr_addr increments, word_count increments.
  - If word_count+1 == target -> CHECK, else -> DATA.
  - wr_addr must not wrap: when target==DEPTH the last write is at DEPTH-1, and wr_addr saturates at DEPTH-1 after that write.
- CHECK: byte_ready=1. Accepted byte == checksum -> DONE, else -> ERROR.
- DONE: done=1, busy=0, cpu_reset=0. start -> HEADER; cpu_reset returns to 1 on the same edge.
- ERROR: error=1, busy=0, cpu_reset stays 1. start -> HEADER.
- busy=1 in HEADER, DATA, WRITE and CHECK. start while busy is ignored.
- done and error are mutually exclusive and remain held until the next start or reset.
- Words already written before an ERROR remain in imem; the loader does not roll them back.
- wr_data holds its last value when wr_en=0.
- Minimum latency from header acceptance to done: 5*target+1 accepted-byte/write cycles when byte_valid is held high.

Decomposition:
- Shared package imem_loader_pkg holds:
  - state enum typedef (IDLE..ERROR)
  - BYTES_PER_WORD=4
  - DEPTH derivation helper
- Sub-module imem_loader_asm (byte-to-word assembler: byte index counter, shift/insert into N-bit buffer, running XOR checksum) is natural.
- The FSM, address counter and output flags stay in the top module.

Test Plan:
- 2-word load: stream 02, 01 00 00 f8, 02 80 00 f8, 83 with byte_valid always high.
  - Writes addr0=f8000001, addr1=f8008002.
  - Then done=1, cpu_reset=0, word_count=2.
- Bad checksum: same stream with last byte 84.
  - Both writes still occur.
  - Then error=1, done=0, cpu_reset=1.
- Header 00 -> ERROR on the next cycle with no wr_en. Header 41h (65) -> ERROR with no wr_en.
- Full load: header 40h (64) with 64 words, where word i = i.
  - Last write at wr_addr=63 with data 0000003f.
  - word_count=64, no write to address 0 after start; done=1.
- Backpressure and start handling:
  - Assert byte_valid continuously; byte_ready=0 during every WRITE cycle and no byte is lost or duplicated (compare the written words).
  - start pulsed mid-DATA is ignored.
- Reset mid-DATA after 6 bytes -> next cycle IDLE, all outputs at reset values, no wr_en afterwards. A subsequent start followed by a 1-word load completes with done=1.
